// File: rtl/vdiv_pkg.sv
// Shared types and default element geometry for the vector divide sequencer.
package vdiv_pkg;

    localparam int unsigned EXP_WIDTH_DEF  = 8;
    localparam int unsigned MANT_WIDTH_DEF = 7;
    localparam int unsigned EW             = EXP_WIDTH_DEF + MANT_WIDTH_DEF + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } vdiv_seq_state_t;

endpackage

// File: rtl/vdiv_seq_if.sv
// Request/response and scalar-divider handshake bundle for vdiv_seq.
interface vdiv_seq_if #(
    parameter int unsigned LANES = 16,
    parameter int unsigned EW    = vdiv_pkg::EW
);

    logic                  req_valid;
    logic                  req_ready;
    logic [LANES*EW-1:0]   req_a;
    logic [LANES*EW-1:0]   req_b;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [LANES*EW-1:0]   resp_data;
    logic                  div_valid_in;
    logic [EW-1:0]         div_op1;
    logic [EW-1:0]         div_op2;
    logic                  div_ready_in;
    logic                  div_valid_out;
    logic [EW-1:0]         div_result;
    logic                  div_ready_out;

    // Sequencer side.
    modport slave (
        input  req_valid, req_a, req_b, resp_ready, div_ready_in, div_valid_out, div_result,
        output req_ready, resp_valid, resp_data, div_valid_in, div_op1, div_op2, div_ready_out
    );

    // Requester, consumer and scalar divider side.
    modport master (
        output req_valid, req_a, req_b, resp_ready, div_ready_in, div_valid_out, div_result,
        input  req_ready, resp_valid, resp_data, div_valid_in, div_op1, div_op2, div_ready_out
    );

endinterface

// File: rtl/vdiv_seq.sv
// Feeds one vector of element pairs through a shared in-order scalar divider and
// collects the quotients into a result vector.
module vdiv_seq
    import vdiv_pkg::*;
#(
    parameter int unsigned EXP_WIDTH  = EXP_WIDTH_DEF,
    parameter int unsigned MANT_WIDTH = MANT_WIDTH_DEF,
    parameter int unsigned LANES      = 16
) (
    input logic       CLK,
    input logic       nRST,
    vdiv_seq_if.slave bus_io
);

    localparam int unsigned ElemW = EXP_WIDTH + MANT_WIDTH + 1;
    localparam int unsigned CntW  = $clog2(LANES + 1);
    localparam int unsigned IdxW  = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [CntW-1:0] NumLanes = CntW'(LANES);
    localparam logic [CntW-1:0] LastLane = CntW'(LANES - 1);

    vdiv_seq_state_t state_q;

    logic [CntW-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CntW-1:0]  retire_cnt_q, retire_cnt_d;
    logic [IdxW-1:0]  issue_idx, retire_idx;
    logic [ElemW-1:0] op_a_q [LANES];
    logic [ElemW-1:0] op_b_q [LANES];
    logic [ElemW-1:0] res_q  [LANES];

    logic req_ready_q, resp_valid_q, div_valid_in_q, div_ready_out_q;
    logic issue_fire, retire_fire;

    // div_ready_out_q is only high in RUN, so stray divider results elsewhere are dropped.
    always_comb begin
        issue_fire   = div_valid_in_q & bus_io.div_ready_in;
        retire_fire  = div_ready_out_q & bus_io.div_valid_out;
        issue_cnt_d  = issue_cnt_q + CntW'(issue_fire);
        retire_cnt_d = retire_cnt_q + CntW'(retire_fire);
        issue_idx    = issue_cnt_q[IdxW-1:0];
        retire_idx   = retire_cnt_q[IdxW-1:0];
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q         <= StIdle;
            issue_cnt_q     <= '0;
            retire_cnt_q    <= '0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            div_valid_in_q  <= 1'b0;
            div_ready_out_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.req_valid) begin
                        for (int i = 0; i < int'(LANES); i++) begin
                            op_a_q[i] <= bus_io.req_a[i*ElemW +: ElemW];
                            op_b_q[i] <= bus_io.req_b[i*ElemW +: ElemW];
                        end
                        issue_cnt_q     <= '0;
                        retire_cnt_q    <= '0;
                        state_q         <= StRun;
                        req_ready_q     <= 1'b0;
                        div_valid_in_q  <= 1'b1;
                        div_ready_out_q <= 1'b1;
                    end
                end
                StRun: begin
                    issue_cnt_q    <= issue_cnt_d;
                    retire_cnt_q   <= retire_cnt_d;
                    div_valid_in_q <= (issue_cnt_d < NumLanes);
                    if (retire_fire) begin
                        res_q[retire_idx] <= bus_io.div_result;
                        if (retire_cnt_q == LastLane) begin
                            state_q         <= StDone;
                            div_valid_in_q  <= 1'b0;
                            div_ready_out_q <= 1'b0;
                            resp_valid_q    <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (bus_io.resp_ready) begin
                        state_q      <= StIdle;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.req_ready     = req_ready_q;
    assign bus_io.resp_valid    = resp_valid_q;
    assign bus_io.div_valid_in  = div_valid_in_q;
    assign bus_io.div_ready_out = div_ready_out_q;
    assign bus_io.div_op1       = op_a_q[issue_idx];
    assign bus_io.div_op2       = op_b_q[issue_idx];

    for (genvar g = 0; g < int'(LANES); g++) begin : g_resp
        assign bus_io.resp_data[g*ElemW +: ElemW] = res_q[g];
    end

endmodule

// File: tb/tb_vdiv_seq.sv
// Self-checking bench for vdiv_seq with a behavioural bf16 scalar divider model.
module tb_vdiv_seq;

    localparam int L = 4;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        int          lat;
        int          exp_cyc;
        int          exp_inf;
        int          exp_sim;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        int          due;
    } pend_t;

    logic CLK;
    logic nRST;

    vdiv_seq_if #(.LANES(L), .EW(16)) bus ();

    vdiv_seq #(
        .EXP_WIDTH (8),
        .MANT_WIDTH(7),
        .LANES     (L)
    ) dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .bus_io(bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    // Divider model state and run statistics.
    pend_t       pipe[$];
    int          cyc = 0;
    int          lat_cfg = 1;
    int          stall_at = -1;
    int          stall_len = 0;
    int          stall_left = 0;
    bit          rnd_ready = 0;
    int          n_iss = 0;
    int          n_ret = 0;
    int          max_inf = 0;
    int          sim_cnt = 0;
    bit          iss_prev = 0;
    bit          ret_prev = 0;
    logic [15:0] op1_prev, op2_prev;
    logic [15:0] exp_a [L];
    logic [15:0] exp_b [L];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference bf16 quotient via double-precision arithmetic (normal operands only).
    function automatic logic [15:0] bf16_div(input logic [15:0] x, input logic [15:0] y);
        real         rx, ry;
        logic [63:0] d;
        logic [10:0] e;
        rx = $bitstoreal({x[15], ({3'b0, x[14:7]} + 11'd896), x[6:0], 45'd0});
        ry = $bitstoreal({y[15], ({3'b0, y[14:7]} + 11'd896), y[6:0], 45'd0});
        d  = $realtobits(rx / ry);
        e  = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:45]};
    endfunction

    function automatic logic [15:0] rand_bf16();
        logic [7:0] e;
        e = 8'($urandom_range(120, 134));
        return {1'($urandom), e, 7'($urandom)};
    endfunction

    // Scalar divider: in order, fixed latency, optional stalls on the issue side.
    always @(negedge CLK) begin
        pend_t p;
        bit    rdy;
        cyc++;
        if (iss_prev) begin
            p.res = bf16_div(op1_prev, op2_prev);
            p.due = cyc + lat_cfg - 1;
            pipe.push_back(p);
            n_iss++;
            if (n_iss == stall_at) stall_left = stall_len;
        end
        if (ret_prev) begin
            void'(pipe.pop_front());
            n_ret++;
            if (n_ret == L) chk("done_after_last_retire", bus.resp_valid, 1);
        end
        if (iss_prev && ret_prev) sim_cnt++;
        if (n_iss - n_ret > max_inf) max_inf = n_iss - n_ret;
        if (!nRST) begin
            pipe.delete();
            stall_left = 0;
        end
        if (stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
        end else begin
            rdy = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        bus.div_ready_in = rdy;
        if (pipe.size() > 0 && pipe[0].due <= cyc) begin
            bus.div_valid_out = 1'b1;
            bus.div_result    = pipe[0].res;
        end else begin
            bus.div_valid_out = 1'b0;
            bus.div_result    = 16'h0;
        end
        iss_prev = nRST && bus.div_valid_in && rdy;
        ret_prev = nRST && bus.div_valid_out && bus.div_ready_out;
        op1_prev = bus.div_op1;
        op2_prev = bus.div_op2;
        if (bus.div_valid_in) begin
            if (n_iss < L) begin
                chk("div_op1_lane", bus.div_op1, exp_a[n_iss]);
                chk("div_op2_lane", bus.div_op2, exp_b[n_iss]);
            end else begin
                chk("issue_beyond_lanes", bus.div_valid_in, 0);
            end
        end
    end

    task automatic start_req(input logic [63:0] a, input logic [63:0] b);
        int k;
        @(negedge CLK);
        n_iss = 0;
        n_ret = 0;
        max_inf = 0;
        sim_cnt = 0;
        for (int i = 0; i < L; i++) begin
            exp_a[i] = a[i*16 +: 16];
            exp_b[i] = b[i*16 +: 16];
        end
        bus.req_a = a;
        bus.req_b = b;
        bus.req_valid = 1'b1;
        k = 0;
        while (!bus.req_ready && k < 50) begin
            @(negedge CLK);
            k++;
        end
        chk("req_accept", bus.req_ready, 1);
        @(negedge CLK);
        bus.req_valid = 1'b0;
    endtask

    task automatic run_req(input logic [63:0] a, input logic [63:0] b, input int hold,
                           output logic [63:0] data, output int lat_meas);
        start_req(a, b);
        lat_meas = 1;
        while (!bus.resp_valid && lat_meas < 400) begin
            @(negedge CLK);
            lat_meas++;
        end
        chk("resp_valid_timeout", bus.resp_valid, 1);
        data = bus.resp_data;
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            @(negedge CLK);
            chk("hold_resp_valid", bus.resp_valid, 1);
            chk("hold_resp_data", bus.resp_data, data);
            chk("hold_req_ready", bus.req_ready, 0);
        end
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge CLK);
        bus.resp_ready = 1'b0;
        chk("release_resp_valid", bus.resp_valid, 0);
        chk("release_req_ready", bus.req_ready, 1);
    endtask

    initial begin
        vec_t        tbl[3];
        logic [63:0] data, ra, rb, rq;
        int          lc, k;

        tbl[0] = '{64'h4000_4040_3F80_40C0, 64'h3F00_4040_4000_4000,
                   64'h4080_3F80_3F00_4040, 1, 6, 1, 3};
        tbl[1] = '{64'h4000_4040_3F80_40C0, 64'h3F00_4040_4000_4000,
                   64'h4080_3F80_3F00_4040, 4, 9, 4, 0};
        tbl[2] = '{64'h3F40_4120_C080_3F80, 64'h3E80_C0A0_4000_4080,
                   64'h4040_C000_C000_3E80, 2, 7, 2, 2};

        nRST = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.resp_ready = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_req_ready", bus.req_ready, 1);
        chk("reset_resp_valid", bus.resp_valid, 0);
        chk("reset_div_valid_in", bus.div_valid_in, 0);
        chk("reset_div_ready_out", bus.div_ready_out, 0);
        nRST = 1'b1;

        for (int t = 0; t < 3; t++) begin
            lat_cfg = tbl[t].lat;
            run_req(tbl[t].a, tbl[t].b, 0, data, lc);
            chk($sformatf("vec%0d_data", t), data, tbl[t].q);
            chk($sformatf("vec%0d_latency", t), lc, tbl[t].exp_cyc);
            chk($sformatf("vec%0d_in_flight", t), max_inf, tbl[t].exp_inf);
            chk($sformatf("vec%0d_simul", t), sim_cnt, tbl[t].exp_sim);
        end

        // Issue-side stall after the second issue, then a consumer that waits 5 cycles.
        lat_cfg = 1;
        stall_at = 2;
        stall_len = 3;
        run_req(tbl[0].a, tbl[0].b, 5, data, lc);
        chk("stall_data", data, tbl[0].q);
        chk("stall_latency", lc, 9);
        stall_at = -1;

        // Reset after two retires abandons the vector.
        lat_cfg = 2;
        start_req(tbl[2].a, tbl[2].b);
        k = 0;
        while (n_ret < 2 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        chk("mid_two_retires", n_ret >= 2, 1);
        nRST = 1'b0;
        @(negedge CLK);
        chk("midrst_req_ready", bus.req_ready, 1);
        chk("midrst_resp_valid", bus.resp_valid, 0);
        chk("midrst_div_valid_in", bus.div_valid_in, 0);
        chk("midrst_div_ready_out", bus.div_ready_out, 0);
        @(negedge CLK);
        nRST = 1'b1;
        lat_cfg = 1;
        run_req(tbl[0].a, tbl[0].b, 0, data, lc);
        chk("after_reset_data", data, tbl[0].q);
        chk("after_reset_latency", lc, 6);

        // Random operands, random divider latency and random issue back-pressure.
        rnd_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < L; i++) begin
                ra[i*16 +: 16] = rand_bf16();
                rb[i*16 +: 16] = rand_bf16();
                rq[i*16 +: 16] = bf16_div(ra[i*16 +: 16], rb[i*16 +: 16]);
            end
            lat_cfg = $urandom_range(1, 5);
            run_req(ra, rb, $urandom_range(0, 2), data, lc);
            chk($sformatf("rand%0d_data", r), data, rq);
        end
        rnd_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

endmodule
